// File: rtl/draw_rect_frame.sv
// Paints a bordered rectangle into a VGA timing/RGB stream.
// Position and stop are latched once per frame at vblank start; two-stage pipeline.
module draw_rect_frame #(
    parameter int unsigned RECT_WIDTH    = 48,
    parameter int unsigned RECT_HEIGHT   = 64,
    parameter int unsigned BORDER        = 2,
    parameter logic [11:0] RECT_COLOUR   = 12'hf00,
    parameter logic [11:0] STOP_COLOUR   = 12'h0f0,
    parameter logic [11:0] BORDER_COLOUR = 12'hfff
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic        stop,
    input  logic [10:0] hcount_in,
    input  logic        hsync_in,
    input  logic        hblnk_in,
    input  logic [10:0] vcount_in,
    input  logic        vsync_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    output logic [10:0] hcount_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic [10:0] vcount_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    // Wide enough that no sum below can wrap.
    localparam logic [13:0] W = 14'(RECT_WIDTH);
    localparam logic [13:0] H = 14'(RECT_HEIGHT);
    localparam logic [13:0] B = 14'(BORDER);

    logic [11:0] xcap_q, ycap_q;
    logic        stopcap_q, vblnk_prev_q;
    logic        vblnk_rise;

    logic [13:0] hc, vc, x0, y0;
    logic        inside_d, border_d;

    logic [10:0] hcount_s1, vcount_s1;
    logic        hsync_s1, hblnk_s1, vsync_s1, vblnk_s1;
    logic [11:0] rgb_s1;
    logic        inside_s1, border_s1, stop_s1;
    logic [11:0] rgb_d;

    assign vblnk_rise = vblnk_in & ~vblnk_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xcap_q       <= '0;
            ycap_q       <= '0;
            stopcap_q    <= 1'b0;
            vblnk_prev_q <= 1'b0;
        end else begin
            vblnk_prev_q <= vblnk_in;
            if (vblnk_rise) begin
                xcap_q    <= xpos;
                ycap_q    <= ypos;
                stopcap_q <= stop;
            end
        end
    end

    assign hc = {3'b000, hcount_in};
    assign vc = {3'b000, vcount_in};
    assign x0 = {2'b00, xcap_q};
    assign y0 = {2'b00, ycap_q};

    // Far edges compare as hc+B >= x0+W so an oversized border cannot underflow.
    always_comb begin
        inside_d = (hc >= x0) && (hc < x0 + W) && (vc >= y0) && (vc < y0 + H);
        border_d = inside_d && ((hc < x0 + B) || (hc + B >= x0 + W) ||
                                (vc < y0 + B) || (vc + B >= y0 + H));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount_s1 <= '0;
            hsync_s1  <= 1'b0;
            hblnk_s1  <= 1'b0;
            vcount_s1 <= '0;
            vsync_s1  <= 1'b0;
            vblnk_s1  <= 1'b0;
            rgb_s1    <= '0;
            inside_s1 <= 1'b0;
            border_s1 <= 1'b0;
            stop_s1   <= 1'b0;
        end else begin
            hcount_s1 <= hcount_in;
            hsync_s1  <= hsync_in;
            hblnk_s1  <= hblnk_in;
            vcount_s1 <= vcount_in;
            vsync_s1  <= vsync_in;
            vblnk_s1  <= vblnk_in;
            rgb_s1    <= rgb_in;
            inside_s1 <= inside_d;
            border_s1 <= border_d;
            stop_s1   <= stopcap_q;
        end
    end

    always_comb begin
        rgb_d = rgb_s1;
        if (hblnk_s1 || vblnk_s1) begin
            rgb_d = 12'h000;
        end else if (border_s1) begin
            rgb_d = BORDER_COLOUR;
        end else if (inside_s1) begin
            rgb_d = stop_s1 ? STOP_COLOUR : RECT_COLOUR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount_out <= '0;
            hsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vcount_out <= '0;
            vsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= hcount_s1;
            hsync_out  <= hsync_s1;
            hblnk_out  <= hblnk_s1;
            vcount_out <= vcount_s1;
            vsync_out  <= vsync_s1;
            vblnk_out  <= vblnk_s1;
            rgb_out    <= rgb_d;
        end
    end

endmodule

// File: tb/tb_draw_rect_frame.sv
// Self-checking bench for draw_rect_frame: per-cycle reference model plus
// hand-computed pixel probes.
module tb_draw_rect_frame;

    localparam int W = 48;
    localparam int H = 64;
    localparam int B = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] xpos, ypos;
    logic        stop;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
    logic [11:0] rgb_in;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
    logic [11:0] rgb_out;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    draw_rect_frame #(
        .RECT_WIDTH   (W),
        .RECT_HEIGHT  (H),
        .BORDER       (B),
        .RECT_COLOUR  (12'hf00),
        .STOP_COLOUR  (12'h0f0),
        .BORDER_COLOUR(12'hfff)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .xpos      (xpos),
        .ypos      (ypos),
        .stop      (stop),
        .hcount_in (hcount_in),
        .hsync_in  (hsync_in),
        .hblnk_in  (hblnk_in),
        .vcount_in (vcount_in),
        .vsync_in  (vsync_in),
        .vblnk_in  (vblnk_in),
        .rgb_in    (rgb_in),
        .hcount_out(hcount_out),
        .hsync_out (hsync_out),
        .hblnk_out (hblnk_out),
        .vcount_out(vcount_out),
        .vsync_out (vsync_out),
        .vblnk_out (vblnk_out),
        .rgb_out   (rgb_out)
    );

    typedef struct packed {
        logic [10:0] hc;
        logic        hs;
        logic        hb;
        logic [10:0] vc;
        logic        vs;
        logic        vb;
        logic [11:0] rgb;
    } out_t;

    // Colour a pixel from the rectangle rules using plain signed offsets.
    function automatic logic [11:0] model_rgb(int hc, int vc, int x, int y, bit st,
                                              bit hb, bit vb, logic [11:0] rin);
        int dx, dy;
        if (hb || vb) return 12'h000;
        dx = hc - x;
        dy = vc - y;
        if (dx < 0 || dx >= W || dy < 0 || dy >= H) return rin;
        if (dx < B || dx >= W - B || dy < B || dy >= H - B) return 12'hfff;
        return st ? 12'h0f0 : 12'hf00;
    endfunction

    out_t e1 = '0;
    out_t e2 = '0;
    int   mx, my;
    bit   ms, mprev;

    // Reference: expected output is the model of the inputs seen two edges ago.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                e1 = '0; e2 = '0; mx = 0; my = 0; ms = 0; mprev = 0;
            end else begin
                e2 = e1;
                e1.hc  = hcount_in;
                e1.hs  = hsync_in;
                e1.hb  = hblnk_in;
                e1.vc  = vcount_in;
                e1.vs  = vsync_in;
                e1.vb  = vblnk_in;
                e1.rgb = model_rgb(int'(hcount_in), int'(vcount_in), mx, my, ms,
                                   hblnk_in, vblnk_in, rgb_in);
                if (vblnk_in && !mprev) begin
                    mx = int'(xpos); my = int'(ypos); ms = stop;
                end
                mprev = vblnk_in;
            end
        end
    end

    initial begin
        out_t act;
        forever begin
            @(negedge clk);
            act = '{hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out,
                    vblnk_out, rgb_out};
            n_cmp++;
            if (act !== e2) begin
                n_fail++;
                $display("FAIL stream t=%0t: got %h, expected %h", $time, act, e2);
            end
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(int h, int v, bit hb, bit vb, logic [11:0] c);
        @(posedge clk);
        #1;
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hblnk_in  = hb;
        vblnk_in  = vb;
        hsync_in  = (h >= 656 && h < 752);
        vsync_in  = (v == 490 || v == 491);
        rgb_in    = c;
    endtask

    task automatic new_frame(int x, int y, bit st);
        xpos = 12'(x); ypos = 12'(y); stop = st;
        drive(0, 480, 1'b1, 1'b1, 12'h000);
        drive(1, 480, 1'b1, 1'b1, 12'h000);
        drive(2, 0, 1'b0, 1'b0, 12'h000);
    endtask

    // One pixel in, one idle cycle, then check the pixel's rgb_out two edges later.
    task automatic probe(string name, int h, int v, bit hb, logic [11:0] c,
                         logic [11:0] exp);
        drive(h, v, hb, 1'b0, c);
        drive(0, 0, 1'b1, 1'b0, 12'h000);
        @(posedge clk);
        @(negedge clk);
        check(name, 32'(rgb_out), 32'(exp));
    endtask

    initial begin
        rst = 1'b1;
        xpos = '0; ypos = '0; stop = 1'b0;
        hcount_in = '0; vcount_in = '0; hsync_in = 0; hblnk_in = 0;
        vsync_in = 0; vblnk_in = 0; rgb_in = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset mid-line.
        for (int h = 10; h < 20; h++) drive(h, 5, 1'b0, 1'b0, 12'h0aa);
        @(posedge clk);
        #1 rst = 1'b1; hcount_in = 11'd20;
        @(negedge clk);
        check("rst_hcount", 32'(hcount_out), 32'd0);
        check("rst_rgb", 32'(rgb_out), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; hcount_in = 11'd77; vcount_in = 11'd5; rgb_in = 12'h321;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_1clk", 32'(hcount_out), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("post_rst_hcount", 32'(hcount_out), 32'd77);
        check("post_rst_rgb", 32'(rgb_out), 32'h321);

        // Pass-through with the rectangle off-screen.
        new_frame(900, 50, 1'b0);
        probe("pass_rgb", 200, 60, 1'b0, 12'h123, 12'h123);

        // Capture at (100,50).
        new_frame(100, 50, 1'b0);
        probe("cap_100_50", 100, 50, 1'b0, 12'h456, 12'hfff);
        probe("cap_102_52", 102, 52, 1'b0, 12'h456, 12'hf00);
        probe("cap_147_113", 147, 113, 1'b0, 12'h456, 12'hfff);
        probe("cap_148_60", 148, 60, 1'b0, 12'h456, 12'h456);
        probe("cap_99_60", 99, 60, 1'b0, 12'h456, 12'h456);

        // Mid-frame position change must not tear.
        xpos = 12'd300;
        probe("tear_old_pos", 102, 52, 1'b0, 12'h456, 12'hf00);
        probe("tear_new_pos", 302, 52, 1'b0, 12'h456, 12'h456);
        new_frame(300, 50, 1'b0);
        probe("next_new_pos", 302, 52, 1'b0, 12'h456, 12'hf00);
        probe("next_old_pos", 102, 52, 1'b0, 12'h456, 12'h456);

        // Stop colour and blanking.
        new_frame(100, 50, 1'b1);
        probe("stop_interior", 110, 70, 1'b0, 12'h456, 12'h0f0);
        probe("stop_border", 100, 70, 1'b0, 12'h456, 12'hfff);
        probe("blank_in_rect", 110, 70, 1'b1, 12'h456, 12'h000);

        // Rectangle hanging off the bottom-right corner.
        new_frame(620, 450, 1'b0);
        probe("edge_639_479", 639, 479, 1'b0, 12'h789, 12'hf00);
        probe("edge_620_450", 620, 450, 1'b0, 12'h789, 12'hfff);
        probe("edge_619_460", 619, 460, 1'b0, 12'h789, 12'h789);
        probe("edge_hblank", 650, 470, 1'b1, 12'h789, 12'h000);

        // Mixed stream checked by the reference model only.
        for (int i = 0; i < 400; i++) begin
            if (i % 100 == 0) begin
                new_frame(int'($urandom_range(80, 120)), int'($urandom_range(30, 60)),
                          1'($urandom_range(0, 1)));
            end
            drive(int'($urandom_range(70, 180)), int'($urandom_range(20, 130)),
                  ($urandom_range(0, 9) == 0), 1'b0, 12'($urandom));
        end
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
